// File: rtl/adder_pkg.sv
// Shared definitions for the time-multiplexed multiword adder.
package adder_pkg;

    localparam int DEF_SLICE_W    = 4;
    localparam int DEF_NUM_SLICES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE_W-bit ripple-carry adder built from a chain of full adders.
module rca_slice
    import adder_pkg::*;
#(
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        logic w_p;
        assign w_p        = i_a[i] ^ i_b[i];
        assign o_sum[i]   = w_p ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_p & w_c[i]);
    end

    assign o_cout = w_c[SLICE_W];

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer: one SLICE_W-bit slice is reused over NUM_SLICES
// cycles, with the inter-slice carry held in a register.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice per cycle, low slice first
// DONE  | result held on sum/cout/ovf until out_ready
module multiword_add_seq
    import adder_pkg::*;
#(
    parameter int SLICE_W    = DEF_SLICE_W,
    parameter int NUM_SLICES = DEF_NUM_SLICES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] a,
    input  logic [SLICE_W*NUM_SLICES-1:0] b,
    input  logic                          cin,
    input  logic                          sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] sum,
    output logic                          cout,
    output logic                          ovf,
    output logic                          busy
);

    localparam int W     = SLICE_W * NUM_SLICES;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b_eff;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;

    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic               w_accept;
    logic               w_last;

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_idx == LAST_IDX);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Select the operand slice addressed by the current slice index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_slice = r_a[k*SLICE_W +: SLICE_W];
                w_b_slice = r_b_eff[k*SLICE_W +: SLICE_W];
            end
        end
    end

    rca_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a retire in DONE may chain straight into a new RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = w_accept ? RUN : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture, per-slice accumulation and final flag capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b_eff <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            // Subtract is a + ~b + 1; cin has no effect in that mode.
            r_a     <= a;
            r_b_eff <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            for (int k = 0; k < NUM_SLICES; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_sum[k*SLICE_W +: SLICE_W] <= w_slice_sum;
                end
            end
            r_carry <= w_slice_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                // Flags are frozen here so they stay stable through DONE and IDLE.
                r_cout <= w_slice_cout;
                r_ovf  <= (r_a[W-1] == r_b_eff[W-1]) &
                          (w_slice_sum[SLICE_W-1] != r_a[W-1]);
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
    logic [15:0] a, b, sum;

    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1, busy1;
    logic [7:0]  a1, b1, sum1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiword_add_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // Single-slice configuration: one RUN cycle per operation.
    multiword_add_seq #(.SLICE_W(8), .NUM_SLICES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .sub       (sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1),
        .busy      (busy1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        int unsigned ua, ub, full;
        int          sa, sb, sres;
        logic        c, o;
        logic [15:0] s;
        ua = ma;
        ub = mb;
        sa = $signed(ma);
        sb = $signed(mb);
        if (msub) begin
            s    = 16'(ua - ub);
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + (mcin ? 1 : 0);
            s    = 16'(full);
            c    = (full > 65535);
            sres = sa + sb + (mcin ? 1 : 0);
        end
        o = (sres > 32767) || (sres < -32768);
        return {o, c, s};
    endfunction

    // From #1 after the accept edge, count edges until out_valid (bounded).
    task automatic wait_result(input bit scramble, output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_n++;
            if (scramble) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                sub = 1'($urandom);
                cin = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                          input logic tsub, input bit scramble,
                          output logic [15:0] rs, output logic rc, output logic ro,
                          output int lat, output int busy_n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(scramble, lat, busy_n);
        rs = sum;
        rc = cout;
        ro = ovf;
    endtask

    logic [15:0] rs;
    logic        rc, ro;
    int          lat, busy_n;
    logic [17:0] exp_v;
    bit          seen;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'h0888, 16'h0888, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        a1        = '0;
        b1        = '0;
        cin1      = 1'b0;
        sub1      = 1'b0;
        out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, rs, rc, ro, lat, busy_n);
            check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].es));
            check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].ec));
            check($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].eo));
            check($sformatf("vec%0d_latency", i), 32'(lat), 4);
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 4);
        end

        // Randomized against the integer model, biased towards edge values.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] ra, rb;
            logic        rcin, rsub;
            case ($urandom_range(0, 4))
                0: ra = 16'hFFFF;
                1: ra = 16'h7FFF;
                2: ra = 16'h8000;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: rb = 16'h0000;
                1: rb = 16'h8000;
                2: rb = 16'h0001;
                default: rb = 16'($urandom);
            endcase
            rcin = 1'($urandom);
            rsub = 1'($urandom);
            exp_v = model(ra, rb, rcin, rsub);
            run_op(ra, rb, rcin, rsub, 1'b0, rs, rc, ro, lat, busy_n);
            check($sformatf("rnd%0d_result", i), {14'd0, ro, rc, rs}, 32'(exp_v));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 4);
        end

        // Inputs wiggled during RUN must not affect the latched operation.
        run_op(16'h0F0F, 16'h1010, 1'b0, 1'b0, 1'b1, rs, rc, ro, lat, busy_n);
        check("scramble_sum", 32'(rs), 32'h1F1F);
        check("scramble_flags", {30'd0, rc, ro}, 0);

        // Backpressure then simultaneous retire/accept.
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check("bp_in_ready_idle", 32'(in_ready), 1);
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(1'b0, lat, busy_n);
        check("bp_first_sum", 32'(sum), 32'h3333);
        check("bp_first_latency", 32'(lat), 4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("bp_hold%0d_sum", i), 32'(sum), 32'h3333);
            check($sformatf("bp_hold%0d_flags", i), {30'd0, cout, ovf}, 0);
            check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 0);
        end
        @(negedge clk);
        a         = 16'h0002;
        b         = 16'h0003;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_retired", 32'(out_valid), 0);
        check("b2b_accepted_busy", 32'(busy), 1);
        wait_result(1'b0, lat, busy_n);
        check("b2b_second_sum", 32'(sum), 32'h0005);
        check("b2b_second_latency", 32'(lat), 4);

        // Reset mid-RUN at slice index 2.
        repeat (2) @(negedge clk);
        a        = 16'h1234;
        b        = 16'h1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_sum", 32'(sum), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_result", 32'(seen), 0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat, busy_n);
        check("postrst_sum", 32'(rs), 32'h0002);
        check("postrst_latency", 32'(lat), 4);

        // Single-slice instance: DONE right after one RUN cycle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("ns1_op%0d_in_ready", i), 32'(in_ready1), 1);
            a1        = (i == 0) ? 8'hF0 : 8'h10;
            b1        = (i == 0) ? 8'h20 : 8'h20;
            cin1      = (i == 0);
            sub1      = (i == 1);
            in_valid1 = 1'b1;
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            check($sformatf("ns1_op%0d_busy", i), {30'd0, busy1, out_valid1}, 32'b10);
            @(posedge clk);
            #1;
            check($sformatf("ns1_op%0d_valid", i), 32'(out_valid1), 1);
            check($sformatf("ns1_op%0d_sum", i), 32'(sum1), (i == 0) ? 32'h11 : 32'hF0);
            check($sformatf("ns1_op%0d_flags", i), {30'd0, cout1, ovf1}, (i == 0) ? 32'b10 : 32'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
